// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   HI/LO multiply/divide unit. mult/multu/div/divu compute their result on the
//   accepting edge, hold it in a pending register while busy counts down, and
//   commit it to HI/LO when the countdown expires. mthi/mtlo write immediately.
//
// Parameters
//   MULT_CYCLES : busy duration of mult/multu (must be >= 1)
//   DIV_CYCLES  : busy duration of div/divu   (must be >= 1)
//
// Ports
//   clk   in   clock, all state changes on rising edge
//   rst   in   synchronous active-high reset
//   start in   op request valid this cycle (ignored while busy)
//   op    in   3'b000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   A     in   rs operand (dividend / multiplicand / mthi-mtlo source)
//   B     in   rt operand (divisor / multiplier)
//   busy  out  multi-cycle op in progress
//   HI    out  architectural HI register
//   LO    out  architectural LO register
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  // Architectural and pending state; initialisers give the reset values at power-up.
  logic             busy_q   = 1'b0;
  logic [CNT_W-1:0] cnt_q    = {CNT_W{1'b0}};
  logic [31:0]      hi_q     = 32'h0000_0000;
  logic [31:0]      lo_q     = 32'h0000_0000;
  logic [31:0]      res_hi_q = 32'h0000_0000;
  logic [31:0]      res_lo_q = 32'h0000_0000;
  logic             res_wr_q = 1'b0;

  logic             busy_d;
  logic [CNT_W-1:0] cnt_d;
  logic [31:0]      hi_d;
  logic [31:0]      lo_d;
  logic [31:0]      res_hi_d;
  logic [31:0]      res_lo_d;
  logic             res_wr_d;

  // ---------------------------------------------------------------------------
  // Shared datapath. op[0]=0 selects the signed flavour for both mult and div.
  // ---------------------------------------------------------------------------
  logic        is_signed;
  logic [63:0] opa_ext;
  logic [63:0] opb_ext;
  logic [63:0] product;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] dvs_safe;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        div_by_zero;

  assign is_signed = ~op[0];

  // Low 64 bits of the product of sign/zero-extended operands equal the
  // signed/unsigned 64-bit product, so one multiplier serves both ops.
  assign opa_ext = {{32{is_signed & A[31]}}, A};
  assign opb_ext = {{32{is_signed & B[31]}}, B};
  assign product = opa_ext * opb_ext;

  // Signed division runs on magnitudes; -(0x80000000) stays 0x80000000 which,
  // read as unsigned, is the correct magnitude, so the overflow case
  // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
  assign a_neg       = is_signed & A[31];
  assign b_neg       = is_signed & B[31];
  assign dvd         = a_neg ? (32'd0 - A) : A;
  assign dvs         = b_neg ? (32'd0 - B) : B;
  assign div_by_zero = (B == 32'd0);
  assign dvs_safe    = div_by_zero ? 32'd1 : dvs;  // keeps the divider defined; result is discarded
  assign quo         = dvd / dvs_safe;
  assign rem         = dvd % dvs_safe;
  assign quo_fix     = (a_neg ^ b_neg) ? (32'd0 - quo) : quo;  // truncate toward zero
  assign rem_fix     = a_neg ? (32'd0 - rem) : rem;            // remainder follows dividend

  // Next-state logic: countdown/commit while busy, otherwise accept a request.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;

    if (busy_q) begin
      if (cnt_q == CNT_ONE) begin
        busy_d   = 1'b0;
        cnt_d    = CNT_ZERO;
        res_wr_d = 1'b0;
        if (res_wr_q) begin
          hi_d = res_hi_q;
          lo_d = res_lo_q;
        end else begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (start) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          busy_d   = 1'b1;
          cnt_d    = MULT_LOAD;
          res_hi_d = product[63:32];
          res_lo_d = product[31:0];
          res_wr_d = 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          busy_d   = 1'b1;
          cnt_d    = DIV_LOAD;
          res_hi_d = rem_fix;
          res_lo_d = quo_fix;
          res_wr_d = ~div_by_zero;  // divide by zero still occupies the unit but commits nothing
        end
        OP_MTHI: begin
          hi_d = A;
        end
        OP_MTLO: begin
          lo_d = A;
        end
        default: begin
          busy_d = busy_q;  // reserved encodings are no-ops
        end
      endcase
    end else begin
      busy_d = busy_q;
    end
  end

  // State registers with synchronous reset that discards any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= CNT_ZERO;
      hi_q     <= 32'h0000_0000;
      lo_q     <= 32'h0000_0000;
      res_hi_q <= 32'h0000_0000;
      res_lo_q <= 32'h0000_0000;
      res_wr_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'b000;
  logic [31:0] A     = 32'h0;
  logic [31:0] B     = 32'h0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [63:0] sb[$];            // expected {HI,LO} at each commit
  logic [31:0] cur_hi = 32'h0;   // bench view of architectural state
  logic [31:0] cur_lo = 32'h0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Independent reference using 64-bit integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
    longint sa, sbv, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ref_result = {h, l};
    case (o)
      3'b000: ref_result = 64'(sa * sbv);
      3'b001: ref_result = ua * ub;
      3'b010: if (b != 32'd0) begin
        q = sa / sbv;
        r = sa % sbv;
        ref_result = {r[31:0], q[31:0]};
      end
      3'b011: if (b != 32'd0) begin
        uq = ua / ub;
        ur = ua % ub;
        ref_result = {ur[31:0], uq[31:0]};
      end
      default: ref_result = {h, l};
    endcase
  endfunction

  // Issue a multi-cycle op and track it through busy to commit.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [63:0] exp_in);
    logic [63:0] exp_v;
    int busy_seen;
    sb.push_back(exp_in);
    start = 1'b1; op = o; A = a; B = b;
    tick();
    start = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < n; i++) begin
      if (i != 0) tick();
      if (busy === 1'b1) busy_seen++;
      tests_run++;
      if (busy !== 1'b1 || HI !== cur_hi || LO !== cur_lo) begin
        tests_failed++;
        $display("FAIL %s hold cycle %0d: busy=%b HI=%h LO=%h, required busy=1 HI=%h LO=%h",
                 tag, i, busy, HI, LO, cur_hi, cur_lo);
      end
    end
    tick();
    exp_v = sb.pop_front();
    tests_run++;
    if (busy !== 1'b0 || HI !== exp_v[63:32] || LO !== exp_v[31:0] || busy_seen != n) begin
      tests_failed++;
      $display("FAIL %s commit: busy=%b HI=%h LO=%h busy_cycles=%0d, required busy=0 HI=%h LO=%h busy_cycles=%0d",
               tag, busy, HI, LO, busy_seen, exp_v[63:32], exp_v[31:0], n);
    end
    cur_hi = exp_v[63:32];
    cur_lo = exp_v[31:0];
  endtask

  // Issue a single-cycle move (or reserved op) and check the immediate result.
  task automatic run_move(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [63:0] exp_in);
    logic [63:0] exp_v;
    sb.push_back(exp_in);
    start = 1'b1; op = o; A = a; B = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    exp_v = sb.pop_front();
    tests_run++;
    if (busy !== 1'b0 || HI !== exp_v[63:32] || LO !== exp_v[31:0]) begin
      tests_failed++;
      $display("FAIL %s: busy=%b HI=%h LO=%h, required busy=0 HI=%h LO=%h",
               tag, busy, HI, LO, exp_v[63:32], exp_v[31:0]);
    end
    cur_hi = exp_v[63:32];
    cur_lo = exp_v[31:0];
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0;
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset: busy=%b HI=%h LO=%h, required busy=0 HI=0 LO=0", busy, HI, LO);
    end
    rst = 1'b0;
    cur_hi = 32'h0;
    cur_lo = 32'h0;
  endtask

  task automatic test_mthi;
    run_move("mthi", OP_MTHI, 32'h1234_5678, {32'h1234_5678, 32'h0000_0000});
    tick();
    tests_run++;
    if (busy !== 1'b0 || HI !== 32'h1234_5678 || LO !== 32'h0) begin
      tests_failed++;
      $display("FAIL mthi_hold: busy=%b HI=%h LO=%h, required busy=0 HI=12345678 LO=0", busy, HI, LO);
    end
  endtask

  task automatic test_mult;
    run_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2, MC, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, MC, {32'h0000_0001, 32'hFFFF_FFFE});
  endtask

  task automatic test_div;
    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, DC, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("divu", OP_DIVU, 32'hFFFF_FFF9, 32'd2, DC, {32'h0000_0001, 32'h7FFF_FFFC});
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC, {32'h0000_0000, 32'h8000_0000});
  endtask

  task automatic test_reserved;
    run_move("rsv110", 3'b110, 32'hAAAA_5555, {cur_hi, cur_lo});
    run_move("rsv111", 3'b111, 32'h5555_AAAA, {cur_hi, cur_lo});
  endtask

  task automatic test_div_zero;
    logic [63:0] exp_v;
    run_move("mthi5", OP_MTHI, 32'd5, {32'd5, cur_lo});
    run_move("mtlo6", OP_MTLO, 32'd6, {32'd5, 32'd6});
    sb.push_back({32'd5, 32'd6});
    start = 1'b1; op = OP_DIVU; A = 32'h0000_1234; B = 32'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < DC; i++) begin
      if (i != 0) tick();
      tests_run++;
      if (busy !== 1'b1 || HI !== 32'd5 || LO !== 32'd6) begin
        tests_failed++;
        $display("FAIL divzero hold cycle %0d: busy=%b HI=%h LO=%h, required busy=1 HI=5 LO=6",
                 i, busy, HI, LO);
      end
      if (i == 3) begin
        start = 1'b1; op = OP_MTLO; A = 32'h0000_0099;  // must be ignored while busy
      end else begin
        start = 1'b0;
      end
    end
    tick();
    exp_v = sb.pop_front();
    tests_run++;
    if (busy !== 1'b0 || HI !== exp_v[63:32] || LO !== exp_v[31:0]) begin
      tests_failed++;
      $display("FAIL divzero commit: busy=%b HI=%h LO=%h, required busy=0 HI=%h LO=%h",
               busy, HI, LO, exp_v[63:32], exp_v[31:0]);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || LO !== 32'd6) begin
      tests_failed++;
      $display("FAIL divzero after: busy=%b LO=%h, required busy=0 LO=6", busy, LO);
    end
    cur_hi = 32'd5;
    cur_lo = 32'd6;
  endtask

  task automatic test_reset_mid;
    sb.push_back({32'h0, 32'd12});
    start = 1'b1; op = OP_MULT; A = 32'd3; B = 32'd4;
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid accept: busy=%b, required 1", busy);
    end
    tick();
    tick();
    // Third busy cycle: reset, with a competing mthi that reset must override.
    rst = 1'b1; start = 1'b1; op = OP_MTHI; A = 32'hDEAD_0001;
    tick();
    rst = 1'b0; start = 1'b0;
    sb.delete();
    cur_hi = 32'h0;
    cur_lo = 32'h0;
    tests_run++;
    if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      tests_failed++;
      $display("FAIL rstmid clear: busy=%b HI=%h LO=%h, required busy=0 HI=0 LO=0", busy, HI, LO);
    end
    for (int i = 0; i < MC + 2; i++) begin
      tick();
      tests_run++;
      if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
        tests_failed++;
        $display("FAIL rstmid late_commit cycle %0d: busy=%b HI=%h LO=%h, required busy=0 HI=0 LO=0",
                 i, busy, HI, LO);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_v;
    sb.push_back({32'h0, 32'd42});
    start = 1'b1; op = OP_MULT; A = 32'd7; B = 32'd6;
    tick();
    A = 32'd16; B = 32'd16;  // start held high: ignored until busy drops
    for (int i = 0; i < MC; i++) begin
      if (i != 0) tick();
      tests_run++;
      if (busy !== 1'b1 || HI !== cur_hi || LO !== cur_lo) begin
        tests_failed++;
        $display("FAIL b2b hold cycle %0d: busy=%b HI=%h LO=%h, required busy=1 HI=%h LO=%h",
                 i, busy, HI, LO, cur_hi, cur_lo);
      end
    end
    tick();
    exp_v = sb.pop_front();
    tests_run++;
    if (busy !== 1'b0 || HI !== exp_v[63:32] || LO !== exp_v[31:0]) begin
      tests_failed++;
      $display("FAIL b2b commit1: busy=%b HI=%h LO=%h, required busy=0 HI=%h LO=%h",
               busy, HI, LO, exp_v[63:32], exp_v[31:0]);
    end
    cur_hi = exp_v[63:32];
    cur_lo = exp_v[31:0];
    sb.push_back({32'h0, 32'd256});
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || HI !== cur_hi || LO !== cur_lo) begin
      tests_failed++;
      $display("FAIL b2b accept2: busy=%b HI=%h LO=%h, required busy=1 HI=%h LO=%h",
               busy, HI, LO, cur_hi, cur_lo);
    end
    for (int i = 1; i < MC; i++) tick();
    tick();
    exp_v = sb.pop_front();
    tests_run++;
    if (busy !== 1'b0 || HI !== exp_v[63:32] || LO !== exp_v[31:0]) begin
      tests_failed++;
      $display("FAIL b2b commit2: busy=%b HI=%h LO=%h, required busy=0 HI=%h LO=%h",
               busy, HI, LO, exp_v[63:32], exp_v[31:0]);
    end
    cur_hi = exp_v[63:32];
    cur_lo = exp_v[31:0];
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom();
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
      if (i == 0) a = 32'h8000_0000;
      run_op("random", o, a, b, (o[1] ? DC : MC), ref_result(o, a, b, cur_hi, cur_lo));
    end
  endtask

  initial begin
    test_reset();
    test_mthi();
    test_mult();
    test_div();
    test_reserved();
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5: busy duration in cycles of mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10: busy duration in cycles of div/divu.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: op request valid this cycle.
REQ-006 The block SHALL have port op, input, 3 bits: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 reserved.
REQ-007 The block SHALL have port A, input, 32 bits: rs operand (dividend / multiplicand / mthi-mtlo source).
REQ-008 The block SHALL have port B, input, 32 bits: rt operand (divisor / multiplier).
REQ-009 The block SHALL have port busy, output, 1 bit: multi-cycle op in progress.
REQ-010 The block SHALL have port HI, output, 32 bits: architectural HI register.
REQ-011 The block SHALL have port LO, output, 32 bits: architectural LO register.

Function
REQ-012 The block SHALL accept start only on a rising edge where busy=0 and rst=0; start while busy=1 SHALL be ignored with no state change.
REQ-013 The block SHALL treat reserved op values with start=1 as no-ops.
REQ-014 The block SHALL, for mthi/mtlo accepted at edge k, write A into HI/LO respectively at edge k, leaving the other register unchanged and busy at 0.
REQ-015 The block SHALL, for mult/multu/div/divu accepted at edge k, latch the result internally at edge k, set busy=1 from edge k through the edge before k+N, and commit HI/LO at edge k+N, where N is MULT_CYCLES or DIV_CYCLES.
REQ-016 The block SHALL deassert busy at the same edge k+N where HI/LO are committed, so a new start is accepted at edge k+N+1 at the earliest.
REQ-017 The block SHALL leave HI/LO at their previous values while busy=1.
REQ-018 The block SHALL compute mult as the signed 64-bit product A*B and multu as the unsigned product, with {HI,LO} = product.
REQ-019 The block SHALL compute div/divu as LO=quotient and HI=remainder, signed or unsigned respectively.
REQ-020 The block SHALL truncate the signed quotient toward zero and give the signed remainder the sign of the dividend.
REQ-021 The block SHALL, for signed division 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000 and HI=0.
REQ-022 The block SHALL, for division with B=0, still assert busy for DIV_CYCLES cycles and leave HI and LO unchanged at completion.
REQ-023 The block SHALL use an internal down-counter of at least 4 bits sized for max(MULT_CYCLES, DIV_CYCLES), loaded with N on accept and decremented each edge while busy.
REQ-024 The block SHALL commit when the counter value is 1 at an edge.
REQ-025 The block SHALL drive busy, HI and LO directly from registers.

Reset
REQ-026 The block SHALL, at a rising edge with rst=1, clear HI=0, LO=0, busy=0 and the counter=0.
REQ-027 The block SHALL, at a reset edge, discard any pending result, including reset mid-operation.
REQ-028 The block SHALL give rst priority over start.
REQ-029 The block SHALL initialise all registers to the reset values at power-up.

Verification
REQ-030 The bench SHALL cover: rst pulse, then mthi A=0x12345678 -> HI=0x12345678 after one edge, LO=0, busy never 1.
REQ-031 The bench SHALL cover: mult A=0xFFFFFFFF, B=2 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; HI/LO unchanged while busy.
REQ-032 The bench SHALL cover: multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
REQ-033 The bench SHALL cover: div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu same operands -> LO=0x7FFFFFFC, HI=1.
REQ-034 The bench SHALL cover: divu with B=0 after HI=5, LO=6 -> busy 10 cycles, HI=5, LO=6 retained; a mtlo issued during busy -> ignored, LO stays 6.
REQ-035 The bench SHALL cover: mult started, rst asserted at cycle 3 of busy -> busy=0, HI=LO=0 next edge, and no late commit after 5 cycles.
